ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 160 ++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 scan-code decoder with held-key tracking, BCD press counter and display map.
// Define PS2_KEY_TRACKER_EXT_EN to decode E0-prefixed (extended) scan codes.
module ps2_key_tracker #(
    parameter int CNT_DIGITS = 3,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              ps2_data_i,
    input  logic                    ps2_ready_i,
    input  logic                    ps2_overflow_i,
    output logic                    ps2_nextdata_n_o,
    output logic                    ps2_clrn_o,
    output logic [7:0]              key_code_o,
    output logic                    key_ext_o,
    output logic                    key_held_o,
    output logic                    evt_valid_o,
    output logic                    evt_break_o,
    output logic [4*CNT_DIGITS-1:0] press_cnt_o,
    output logic [4*NUM_DIGITS-1:0] disp_data_o,
    output logic [NUM_DIGITS-1:0]   select_o
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t                  state, state_nxt;
    logic                    accept, is_f0, is_e0, drop;
    logic                    ev_fire, ev_brk, ev_ext;
    logic                    make_new, break_match;
    logic                    carry;
    logic [4*CNT_DIGITS-1:0] cnt_inc;

    assign accept = ps2_ready_i & ~ps2_overflow_i & ps2_nextdata_n_o;
    assign is_f0  = (ps2_data_i == 8'hF0);
    assign is_e0  = (ps2_data_i == 8'hE0);

`ifdef PS2_KEY_TRACKER_EXT_EN
    assign drop = 1'b0;
`else
    // Extended prefixes are consumed but never change decoder state.
    assign drop = is_e0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ev_fire   = 1'b0;
        ev_brk    = 1'b0;
        ev_ext    = 1'b0;
        if (ps2_overflow_i) begin
            state_nxt = IDLE;
        end else if (accept && !drop) begin
            case (state)
                IDLE: begin
                    if (is_f0)      state_nxt = BRK;
                    else if (is_e0) state_nxt = EXT;
                    else            ev_fire   = 1'b1;
                end
                EXT: begin
                    if (is_f0) begin
                        state_nxt = EXT_BRK;
                    end else begin
                        ev_fire   = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    ev_fire   = 1'b1;
                    ev_brk    = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    ev_fire   = 1'b1;
                    ev_brk    = 1'b1;
                    ev_ext    = 1'b1;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign make_new    = ev_fire & ~ev_brk &
                         (~key_held_o | (ps2_data_i != key_code_o) | (ev_ext != key_ext_o));
    assign break_match = ev_fire & ev_brk &
                         (ps2_data_i == key_code_o) & (ev_ext == key_ext_o);

    // Decimal ripple increment; all-nines rolls over to zero.
    always_comb begin
        cnt_inc = press_cnt_o;
        carry   = 1'b1;
        for (int i = 0; i < CNT_DIGITS; i++) begin
            if (carry) begin
                if (press_cnt_o[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = press_cnt_o[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2_nextdata_n_o <= 1'b1;
            ps2_clrn_o       <= 1'b0;
            key_code_o       <= 8'h00;
            key_held_o       <= 1'b0;
            evt_valid_o      <= 1'b0;
            evt_break_o      <= 1'b0;
            press_cnt_o      <= '0;
        end else begin
            ps2_clrn_o  <= ~(ps2_overflow_i & ps2_clrn_o);
            evt_valid_o <= ev_fire;
            evt_break_o <= ev_fire & ev_brk;
            if (ps2_overflow_i) begin
                ps2_nextdata_n_o <= 1'b1;
                key_held_o       <= 1'b0;
            end else begin
                ps2_nextdata_n_o <= ~accept;
                if (make_new) begin
                    key_code_o  <= ps2_data_i;
                    key_held_o  <= 1'b1;
                    press_cnt_o <= cnt_inc;
                end else if (break_match) begin
                    key_held_o  <= 1'b0;
                end
            end
        end
    end

`ifdef PS2_KEY_TRACKER_EXT_EN
    logic key_ext_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         key_ext_q <= 1'b0;
        else if (make_new) key_ext_q <= ev_ext;
    end

    assign key_ext_o = key_ext_q;
`else
    assign key_ext_o = 1'b0;
`endif

    always_comb begin
        disp_data_o                       = '0;
        disp_data_o[3:0]                  = key_code_o[3:0];
        disp_data_o[7:4]                  = key_code_o[7:4];
        disp_data_o[8 +: 4*CNT_DIGITS]    = press_cnt_o;
        select_o                          = '0;
        select_o[1:0]                     = {2{key_held_o}};
        select_o[2 +: CNT_DIGITS]         = '1;
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed self-checking bench for ps2_key_tracker (3-digit and 1-digit counters).
module tb_ps2_key_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ps2_data;
    logic        ps2_ready;
    logic        ps2_overflow;

    logic        nextdata_n, clrn, key_ext, key_held, evt_valid, evt_break;
    logic [7:0]  key_code;
    logic [11:0] press_cnt;
    logic [31:0] disp_data;
    logic [7:0]  select;

    logic        nextdata_n1, clrn1, key_ext1, key_held1, evt_valid1, evt_break1;
    logic [7:0]  key_code1;
    logic [3:0]  press_cnt1;
    logic [11:0] disp_data1;
    logic [2:0]  select1;

    int          n_total = 0;
    int          n_pass  = 0;
    int          pulses  = 0;
    logic        ev_v, ev_b, pop_lo, pop_hi;
    logic [7:0]  codes [10];

    ps2_key_tracker #(.CNT_DIGITS(3), .NUM_DIGITS(8)) u_dut (
        .clk(clk), .reset(reset), .ps2_data_i(ps2_data), .ps2_ready_i(ps2_ready),
        .ps2_overflow_i(ps2_overflow), .ps2_nextdata_n_o(nextdata_n), .ps2_clrn_o(clrn),
        .key_code_o(key_code), .key_ext_o(key_ext), .key_held_o(key_held),
        .evt_valid_o(evt_valid), .evt_break_o(evt_break), .press_cnt_o(press_cnt),
        .disp_data_o(disp_data), .select_o(select)
    );

    ps2_key_tracker #(.CNT_DIGITS(1), .NUM_DIGITS(3)) u_dut1 (
        .clk(clk), .reset(reset), .ps2_data_i(ps2_data), .ps2_ready_i(ps2_ready),
        .ps2_overflow_i(ps2_overflow), .ps2_nextdata_n_o(nextdata_n1), .ps2_clrn_o(clrn1),
        .key_code_o(key_code1), .key_ext_o(key_ext1), .key_held_o(key_held1),
        .evt_valid_o(evt_valid1), .evt_break_o(evt_break1), .press_cnt_o(press_cnt1),
        .disp_data_o(disp_data1), .select_o(select1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Presents one byte at a negedge; returns at the negedge two cycles later.
    task automatic send(input logic [7:0] b);
        ps2_data  = b;
        ps2_ready = 1'b1;
        @(negedge clk);
        ev_v      = evt_valid;
        ev_b      = evt_break;
        pop_lo    = nextdata_n;
        pulses    = pulses + int'(evt_valid);
        ps2_ready = 1'b0;
        @(negedge clk);
        pop_hi    = nextdata_n;
        pulses    = pulses + int'(evt_valid);
    endtask

    initial begin
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
        reset = 1'b1; ps2_data = 8'h00; ps2_ready = 1'b0; ps2_overflow = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_nextdata", nextdata_n, 1);
        check("rst_clrn", clrn, 0);
        check("rst_code", key_code, 0);
        check("rst_ext", key_ext, 0);
        check("rst_held", key_held, 0);
        check("rst_evt", {evt_valid, evt_break}, 0);
        check("rst_cnt", press_cnt, 0);
        check("rst_select", select, 8'b0001_1100);
        check("rst_disp", disp_data, 0);
        check("rst_select1", select1, 3'b100);
        reset = 1'b0;
        @(negedge clk);
        check("clrn_release", clrn, 1);

        // Single make
        pulses = 0;
        send(8'h1C);
        check("mk_evt", {ev_v, ev_b}, 2'b10);
        check("mk_pop_lo", pop_lo, 0);
        check("mk_pop_hi", pop_hi, 1);
        check("mk_code", key_code, 8'h1C);
        check("mk_held", key_held, 1);
        check("mk_cnt", press_cnt, 12'h001);
        check("mk_select", select, 8'b0001_1111);
        check("mk_disp", disp_data, 32'h0000_011C);

        // Typematic repeats then break
        send(8'h1C);
        send(8'h1C);
        check("rep_cnt", press_cnt, 12'h001);
        send(8'hF0);
        check("prefix_no_evt", ev_v, 0);
        send(8'h1C);
        check("brk_evt", {ev_v, ev_b}, 2'b11);
        check("brk_pulses", pulses, 4);
        check("brk_held", key_held, 0);
        check("brk_cnt", press_cnt, 12'h001);
        check("brk_select", select, 8'b0001_1100);

        // New key while another held
        send(8'h32);
        send(8'h1C);
        check("roll_code", key_code, 8'h1C);
        check("roll_cnt", press_cnt, 12'h003);

        // Break prefix then overflow; a byte offered during overflow is ignored
        send(8'hF0);
        ps2_overflow = 1'b1; ps2_data = 8'h55; ps2_ready = 1'b1;
        @(negedge clk);
        check("ovf_clrn_lo", clrn, 0);
        check("ovf_no_pop", nextdata_n, 1);
        check("ovf_held", key_held, 0);
        ps2_overflow = 1'b0; ps2_ready = 1'b0;
        @(negedge clk);
        check("ovf_clrn_hi", clrn, 1);
        check("ovf_code_kept", key_code, 8'h1C);
        send(8'h1C);
        check("ovf_make_evt", {ev_v, ev_b}, 2'b10);
        check("ovf_make_cnt", press_cnt, 12'h004);
        check("ovf_make_held", key_held, 1);

        // Extended prefix handling
        send(8'hE0);
        send(8'h75);
`ifdef PS2_KEY_TRACKER_EXT_EN
        check("ext_first_ext", key_ext, 1);
        check("ext_first_cnt", press_cnt, 12'h005);
        send(8'h75);
        check("ext_second_ext", key_ext, 0);
        check("ext_second_cnt", press_cnt, 12'h006);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_brk_evt", {ev_v, ev_b}, 2'b11);
        check("ext_brk_held", key_held, 1);
`else
        check("ext_first_ext", key_ext, 0);
        check("ext_first_cnt", press_cnt, 12'h005);
        send(8'h75);
        check("ext_second_ext", key_ext, 0);
        check("ext_second_cnt", press_cnt, 12'h005);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_brk_evt", {ev_v, ev_b}, 2'b11);
        check("ext_brk_held", key_held, 0);
`endif

        // Reset between prefix and code
        send(8'hE0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_cnt", press_cnt, 12'h000);
        send(8'h75);
        check("mid_rst_evt", {ev_v, ev_b}, 2'b10);
        check("mid_rst_code", key_code, 8'h75);
        check("mid_rst_ext", key_ext, 0);
        check("mid_rst_cnt1", press_cnt, 12'h001);

        // Ten distinct make/break pairs: decimal carry and 1-digit wrap
        for (int i = 0; i < 10; i++) begin
            send(codes[i]);
            send(8'hF0);
            send(codes[i]);
            if (i == 7) begin
                check("cnt_009", press_cnt, 12'h009);
                check("cnt1_9", press_cnt1, 4'h9);
            end
            if (i == 8) begin
                check("cnt_carry", press_cnt, 12'h010);
                check("cnt1_wrap", press_cnt1, 4'h0);
            end
        end
        check("end_cnt", press_cnt, 12'h011);
        check("end_held", key_held, 0);
        check("end_disp", disp_data, 32'h0000_114D);
        check("end_select", select, 8'b0001_1100);
        check("end_disp1", disp_data1, 12'h14D);
        check("end_select1", select1, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
